mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multicycle sequencer for the CPU datapath: a Moore state machine that steps each instruction through fetch, decode, address/execute, memory and writeback cycles, driving the shared ALU, memory port, register file and PC enables. It contains the ALU-control/flag-write decode and the conditional-execution logic (NZCV flag register plus condition check). It sits in `ControlUnit` beside the instruction decode and is the sole source of datapath enables.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `Cond`  in  4  instruction condition field [31:28]
- `Op`  in  2  instruction [27:26]
- `Funct`  in  6  instruction [25:20]; [5]=I, [4:1]=cmd, [0]=S/L
- `Rd`  in  4  destination register
- `ALUFlags`  in  4  {N,Z,C,V} from ALU, same cycle
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address: 0=PC, 1=ALUOut
- `MemWrite`  out  1  data memory write strobe
- `IRWrite`  out  1  instruction register enable
- `RegWrite`  out  1  register file write enable
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALUResult
- `ALUSrcA`  out  1  0=RD1, 1=PC
- `ALUSrcB`  out  2  00=RD2, 01=ExtImm, 10=constant 4
- `ImmSrc`  out  2  = `Op`
- `RegSrc`  out  2  [0]=(Op==10), [1]=(Op==01 & !Funct[0])
- `ALUControl`  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- `State`  out  4  current state encoding (debug)
- `Illegal`  out  1  high while in UNKNOWN

## Operation

- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, UNKNOWN=10; encodings 11-15 unreachable, recover to FETCH.
- Transitions: FETCH→DECODE. DECODE: Op=01→MEMADR; Op=00 & !Funct[5]→EXECR; Op=00 & Funct[5]→EXECI; Op=10→BRANCH; Op=11→UNKNOWN. MEMADR: Funct[0]→MEMRD else MEMWR. MEMRD→MEMWB→FETCH. MEMWR→FETCH. EXECR/EXECI→ALUWB→FETCH. BRANCH→FETCH. UNKNOWN→FETCH.
- Per-state controls (unlisted = 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode: if ALUOp, cmd 0100→00, 0010→01, 0000→10, 1100→11, other→00. FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & ALUControl∈{00,01}. If !ALUOp: ALUControl=00, FlagW=00.
- Condition check: CondEx from `Cond` and stored Flags per ARM codes 0000-1101; 1110 always true; 1111 false.
- Flags: NZ loads `ALUFlags[3:2]` when FlagW[1] & CondEx; CV loads `ALUFlags[1:0]` when FlagW[0] & CondEx.
- CondExR: registered CondEx, updated every cycle.
- Gated outputs: RegWrite=RegW & CondExR; MemWrite=MemW & CondExR; PCS=Branch | (RegW & Rd==1111); PCWrite=NextPC | (PCS & CondExR).

## Timing

- Reset (async, `reset`=0): state=FETCH, Flags=0000, CondExR=0. Outputs show FETCH decode (IRWrite=1, PCWrite=1, RegWrite=0, MemWrite=0, State=0, Illegal=0). The datapath is held in reset simultaneously. Release is synchronous to next `clk` edge.
- Cycles per instruction: LDR 5, STR 4, DP 4, B 3, illegal 3.
- CondExR is sampled in the cycle before each gated write (DECODE for BRANCH, MEMADR for MEMWR, EXEC for ALUWB, MEMRD for MEMWB). A flag update in EXEC therefore never affects that instruction's own ALUWB.
- Reset asserted mid-instruction aborts it; no write enable may glitch high after `reset` falls.

## Structure

- Package `mc_pkg`: state enum, ALUControl encodings, ResultSrc/ALUSrcB encodings, Cond code constants.
- Sub-module `cond_logic`: Flags register, CondEx, CondExR, FlagWrite gating. The FSM and ALU decode stay in `mc_control_unit`.

## Test plan

- ADD R1,R2,R3 (Op=00, Funct=001000, Cond=1110): State 0→1→6→8→0; ALUControl=00 in EXECR; RegWrite=1 only in ALUWB.
- LDR (Op=01, Funct[0]=1): states 0,1,2,3,4,0; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. STR (Funct[0]=0): MemWrite=1 single cycle in MEMWR.
- SUBS with ALUFlags=0100: Z set. Following BEQ (Cond=0000, Op=10): PCWrite=1 in BRANCH. With Z=0: PCWrite=0 in BRANCH.
- ANDS with ALUFlags=1011 after C=V=0: NZ=10 and CV stay 00. Cond=1111 ADD: RegWrite stays 0 in ALUWB.
- Op=11: State reaches 10, Illegal=1 for one cycle, then FETCH; no write enable asserted.
- `reset` pulled low during MEMWR: MemWrite drops immediately, State=0, Flags=0000.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECR   = 4'd6,
      S_EXECI   = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_UNKNOWN = 4'd10
   } state_e;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCB_RD2    = 2'b00;
   localparam logic [1:0] SRCB_EXTIMM = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;

   function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
      case (cmd)
         4'b0100: return ALU_ADD;
         4'b0010: return ALU_SUB;
         4'b0000: return ALU_AND;
         4'b1100: return ALU_ORR;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_if.sv
// Instruction fields in, datapath enables out; master is the control unit side.
interface mc_if;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic [1:0] ALUControl;
   logic [3:0] State;
   logic       Illegal;

   modport master (
      input  Cond, Op, Funct, Rd, ALUFlags,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State, Illegal
   );

   modport slave (
      output Cond, Op, Funct, Rd, ALUFlags,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State, Illegal
   );
endinterface

// File: rtl/cond_logic.sv
// NZCV flag register, condition evaluation and the registered condition
// result that gates every architectural write of the current instruction.
module cond_logic
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] i_cond,
   input  logic [3:0] i_alu_flags,
   input  logic [1:0] i_flag_w,
   output logic       o_cond_ex_r
);

   logic [3:0] r_flags;
   logic       r_cond_ex;
   logic       w_cond_ex;
   logic       w_n, w_z, w_c, w_v, w_ge;

   assign {w_n, w_z, w_c, w_v} = r_flags;
   assign w_ge = (w_n == w_v);

   always_comb begin
      w_cond_ex = 1'b0;
      case (i_cond)
         COND_EQ: w_cond_ex = w_z;
         COND_NE: w_cond_ex = !w_z;
         COND_CS: w_cond_ex = w_c;
         COND_CC: w_cond_ex = !w_c;
         COND_MI: w_cond_ex = w_n;
         COND_PL: w_cond_ex = !w_n;
         COND_VS: w_cond_ex = w_v;
         COND_VC: w_cond_ex = !w_v;
         COND_HI: w_cond_ex = w_c && !w_z;
         COND_LS: w_cond_ex = !w_c || w_z;
         COND_GE: w_cond_ex = w_ge;
         COND_LT: w_cond_ex = !w_ge;
         COND_GT: w_cond_ex = !w_z && w_ge;
         COND_LE: w_cond_ex = w_z || !w_ge;
         COND_AL: w_cond_ex = 1'b1;
         default: w_cond_ex = 1'b0;
      endcase
   end

   // Flags and the gating bit share an edge, so a write-back always sees the
   // condition as evaluated before its own EXEC flag update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flags   <= 4'b0000;
         r_cond_ex <= 1'b0;
      end else begin
         r_cond_ex <= w_cond_ex;
         if (i_flag_w[1] && w_cond_ex) r_flags[3:2] <= i_alu_flags[3:2];
         if (i_flag_w[0] && w_cond_ex) r_flags[1:0] <= i_alu_flags[1:0];
      end
   end

   assign o_cond_ex_r = r_cond_ex;

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle Moore sequencer driving all datapath enables.
//   state   | meaning
//   FETCH   | read instruction at PC, PC += 4
//   DECODE  | read registers, PC+8 on ALU
//   MEMADR  | compute load/store address
//   MEMRD   | read data memory
//   MEMWB   | write loaded data to register file
//   MEMWR   | write data memory
//   EXECR   | ALU op with register operand
//   EXECI   | ALU op with immediate operand
//   ALUWB   | write ALU result to register file
//   BRANCH  | compute branch target, load PC
//   UNKNOWN | illegal opcode, no writes
module mc_control_unit
   import mc_pkg::*;
(
   input  logic clk,
   input  logic reset,
   mc_if.master bus
);

   state_e     r_state;
   state_e     w_next;
   logic       w_next_pc, w_branch, w_reg_w, w_mem_w, w_alu_op;
   logic       w_adr_src, w_ir_write, w_alu_src_a;
   logic [1:0] w_result_src, w_alu_src_b;
   logic [1:0] w_alu_control, w_flag_w;
   logic       w_cond_ex_r, w_pcs;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next       = S_FETCH;
      w_next_pc    = 1'b0;
      w_branch     = 1'b0;
      w_reg_w      = 1'b0;
      w_mem_w      = 1'b0;
      w_alu_op     = 1'b0;
      w_adr_src    = 1'b0;
      w_ir_write   = 1'b0;
      w_alu_src_a  = 1'b0;
      w_result_src = RES_ALUOUT;
      w_alu_src_b  = SRCB_RD2;
      case (r_state)
         S_FETCH: begin
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = SRCB_FOUR;
            w_result_src = RES_ALURESULT;
            w_ir_write   = 1'b1;
            w_next_pc    = 1'b1;
            w_next       = S_DECODE;
         end
         S_DECODE: begin
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = SRCB_FOUR;
            w_result_src = RES_ALURESULT;
            case (bus.Op)
               2'b00:   w_next = bus.Funct[5] ? S_EXECI : S_EXECR;
               2'b01:   w_next = S_MEMADR;
               2'b10:   w_next = S_BRANCH;
               default: w_next = S_UNKNOWN;
            endcase
         end
         S_MEMADR: begin
            w_alu_src_b = SRCB_EXTIMM;
            w_next      = bus.Funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            w_adr_src = 1'b1;
            w_next    = S_MEMWB;
         end
         S_MEMWB: begin
            w_result_src = RES_DATA;
            w_reg_w      = 1'b1;
         end
         S_MEMWR: begin
            w_adr_src = 1'b1;
            w_mem_w   = 1'b1;
         end
         S_EXECR: begin
            w_alu_op = 1'b1;
            w_next   = S_ALUWB;
         end
         S_EXECI: begin
            w_alu_src_b = SRCB_EXTIMM;
            w_alu_op    = 1'b1;
            w_next      = S_ALUWB;
         end
         S_ALUWB: w_reg_w = 1'b1;
         S_BRANCH: begin
            w_alu_src_b  = SRCB_EXTIMM;
            w_result_src = RES_ALURESULT;
            w_branch     = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // CV is only meaningful for arithmetic ops, so logical ops leave it alone.
   assign w_alu_control = w_alu_op ? alu_decode(bus.Funct[4:1]) : ALU_ADD;
   assign w_flag_w      = w_alu_op ?
      {bus.Funct[0], bus.Funct[0] && (w_alu_control == ALU_ADD || w_alu_control == ALU_SUB)}
      : 2'b00;

   cond_logic u_cond (
      .clk         (clk),
      .reset       (reset),
      .i_cond      (bus.Cond),
      .i_alu_flags (bus.ALUFlags),
      .i_flag_w    (w_flag_w),
      .o_cond_ex_r (w_cond_ex_r)
   );

   assign w_pcs          = w_branch || (w_reg_w && bus.Rd == 4'b1111);
   assign bus.PCWrite    = w_next_pc || (w_pcs && w_cond_ex_r);
   assign bus.RegWrite   = w_reg_w && w_cond_ex_r;
   assign bus.MemWrite   = w_mem_w && w_cond_ex_r;
   assign bus.AdrSrc     = w_adr_src;
   assign bus.IRWrite    = w_ir_write;
   assign bus.ResultSrc  = w_result_src;
   assign bus.ALUSrcA    = w_alu_src_a;
   assign bus.ALUSrcB    = w_alu_src_b;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = {bus.Op == 2'b01 && !bus.Funct[0], bus.Op == 2'b10};
   assign bus.ALUControl = w_alu_control;
   assign bus.State      = r_state;
   assign bus.Illegal    = (r_state == S_UNKNOWN);

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench: each instruction queues its expected per-cycle control
// vector; a negedge monitor pops and compares against the DUT.
module tb_mc_control_unit;

   logic clk = 1'b0;
   logic reset;

   mc_if u_if ();

   mc_control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic       regw;
      logic [1:0] res;
      logic       srca;
      logic [1:0] srcb;
      logic [1:0] imm;
      logic [1:0] regsrc;
      logic [1:0] aluc;
      logic       ill;
   } exp_t;

   exp_t       q[$];
   int         tests = 0;
   int         fails = 0;
   bit         mon_en = 1'b0;
   logic [3:0] m_flags = 4'b0000;   // reference NZCV

   function automatic exp_t actual();
      exp_t a;
      a.st = u_if.State;         a.pcw = u_if.PCWrite;  a.adr = u_if.AdrSrc;
      a.memw = u_if.MemWrite;    a.irw = u_if.IRWrite;  a.regw = u_if.RegWrite;
      a.res = u_if.ResultSrc;    a.srca = u_if.ALUSrcA; a.srcb = u_if.ALUSrcB;
      a.imm = u_if.ImmSrc;       a.regsrc = u_if.RegSrc;
      a.aluc = u_if.ALUControl;  a.ill = u_if.Illegal;
      return a;
   endfunction

   // ARM condition codes evaluated on the architectural flags
   function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] alu_ref(input logic [3:0] cmd);
      if (cmd == 4'd4)  return 2'd0;
      if (cmd == 4'd2)  return 2'd1;
      if (cmd == 4'd0)  return 2'd2;
      if (cmd == 4'd12) return 2'd3;
      return 2'd0;
   endfunction

   task automatic chk(input string nm, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e, a;
      if (mon_en) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_underflow t=%0t state=%0d", $time, u_if.State);
         end else begin
            e = q.pop_front();
            a = actual();
            if (a !== e) begin
               fails++;
               $display("FAIL cycle t=%0t want_state=%0d got=%h want=%h", $time, e.st, a, e);
            end
         end
      end
   end

   // Issue one instruction; expect the first lim cycles of its trace.
   task automatic run_instr(input logic [3:0] c, input logic [1:0] op,
                            input logic [5:0] f, input logic [3:0] rd,
                            input logic [3:0] af, input int lim);
      exp_t tr[$];
      exp_t b, e;
      bit   ce, wr_pc;
      int   n;
      u_if.Cond = c; u_if.Op = op; u_if.Funct = f; u_if.Rd = rd; u_if.ALUFlags = af;
      ce    = cond_holds(c, m_flags);
      wr_pc = ce && (rd == 4'hF);
      b = '0;
      b.imm = op;
      b.regsrc = {op == 2'b01 && !f[0], op == 2'b10};
      e = b; e.st = 4'd0; e.pcw = 1; e.irw = 1; e.srca = 1; e.srcb = 2'd2; e.res = 2'd2;
      tr.push_back(e);
      e = b; e.st = 4'd1; e.srca = 1; e.srcb = 2'd2; e.res = 2'd2;
      tr.push_back(e);
      if (op == 2'b01) begin
         e = b; e.st = 4'd2; e.srcb = 2'd1; tr.push_back(e);
         if (f[0]) begin
            e = b; e.st = 4'd3; e.adr = 1; tr.push_back(e);
            e = b; e.st = 4'd4; e.res = 2'd1; e.regw = ce; e.pcw = wr_pc; tr.push_back(e);
         end else begin
            e = b; e.st = 4'd5; e.adr = 1; e.memw = ce; tr.push_back(e);
         end
      end else if (op == 2'b00) begin
         e = b; e.st = f[5] ? 4'd7 : 4'd6; e.srcb = f[5] ? 2'd1 : 2'd0;
         e.aluc = alu_ref(f[4:1]); tr.push_back(e);
         e = b; e.st = 4'd8; e.res = 2'd0; e.regw = ce; e.pcw = wr_pc; tr.push_back(e);
      end else if (op == 2'b10) begin
         e = b; e.st = 4'd9; e.srcb = 2'd1; e.res = 2'd2; e.pcw = ce; tr.push_back(e);
      end else begin
         e = b; e.st = 4'd10; e.ill = 1; tr.push_back(e);
      end
      n = (lim < tr.size()) ? lim : tr.size();
      for (int i = 0; i < n; i++) q.push_back(tr[i]);
      if (op == 2'b00 && f[0] && ce && n >= 3) begin
         m_flags[3:2] = af[3:2];
         if (alu_ref(f[4:1]) <= 2'd1) m_flags[1:0] = af[1:0];
      end
      reset  = 1'b1;
      mon_en = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] c, rd, af, cmd;
      logic [1:0] op;
      logic [5:0] f;
      int         r;
      u_if.Cond = 4'h0; u_if.Op = 2'b00; u_if.Funct = 6'h00; u_if.Rd = 4'h0; u_if.ALUFlags = 4'h0;
      reset = 1'b1;
      #3 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state",    int'(u_if.State),    0);
      chk("rst_pcwrite",  int'(u_if.PCWrite),  1);
      chk("rst_irwrite",  int'(u_if.IRWrite),  1);
      chk("rst_regwrite", int'(u_if.RegWrite), 0);
      chk("rst_memwrite", int'(u_if.MemWrite), 0);
      chk("rst_illegal",  int'(u_if.Illegal),  0);

      run_instr(4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000, 99);  // ADD
      run_instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, 99);  // LDR
      run_instr(4'hE, 2'b01, 6'b011000, 4'd2, 4'b0000, 99);  // STR
      run_instr(4'hE, 2'b00, 6'b000101, 4'd3, 4'b0100, 99);  // SUBS -> Z
      run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 99);  // BEQ taken
      run_instr(4'hE, 2'b00, 6'b000101, 4'd3, 4'b0000, 99);  // SUBS -> clear
      run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 99);  // BEQ not taken
      run_instr(4'hE, 2'b00, 6'b000001, 4'd4, 4'b1011, 99);  // ANDS
      run_instr(4'h2, 2'b10, 6'b000000, 4'd0, 4'b0000, 99);  // BCS: C stayed 0
      run_instr(4'h4, 2'b10, 6'b000000, 4'd0, 4'b0000, 99);  // BMI: N set
      run_instr(4'hF, 2'b00, 6'b001000, 4'd1, 4'b0000, 99);  // never-ADD
      run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, 99);  // illegal
      run_instr(4'hE, 2'b00, 6'b101000, 4'hF, 4'b0000, 99);  // ADD PC,imm
      run_instr(4'hE, 2'b00, 6'b011000, 4'd5, 4'b0000, 99);  // ORR

      for (int k = 0; k < 120; k++) begin
         r = $urandom_range(0, 9);
         op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         case ($urandom_range(0, 4))
            0: cmd = 4'd4;
            1: cmd = 4'd2;
            2: cmd = 4'd0;
            3: cmd = 4'd12;
            default: cmd = 4'($urandom_range(0, 15));
         endcase
         f  = {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))};
         c  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
         rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         af = 4'($urandom_range(0, 15));
         run_instr(c, op, f, rd, af, 99);
      end

      // Reset in the middle of a store must kill the write and clear flags.
      run_instr(4'hE, 2'b00, 6'b000101, 4'd3, 4'b0100, 99);
      run_instr(4'hE, 2'b01, 6'b011000, 4'd2, 4'b0000, 3);
      mon_en = 1'b0;
      chk("memwr_state",    int'(u_if.State),    5);
      chk("memwr_memwrite", int'(u_if.MemWrite), 1);
      #2 reset = 1'b0;
      #1;
      chk("abort_memwrite", int'(u_if.MemWrite), 0);
      chk("abort_state",    int'(u_if.State),    0);
      chk("abort_regwrite", int'(u_if.RegWrite), 0);
      chk("abort_pcwrite",  int'(u_if.PCWrite),  1);
      m_flags = 4'b0000;
      @(posedge clk);
      #1;
      run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 99);  // BEQ after flags cleared
      run_instr(4'h1, 2'b00, 6'b001000, 4'd1, 4'b0000, 99);  // ADDNE

      chk("queue_drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
